nolinear_ctrl: RTL and testbench
================================

NOLINEAR_CTRL -- requirements
Module: nolinear_ctrl

Interface
REQ-001 Parameter FIX_POINT_WIDTH, default 16, is the element width in bits.
REQ-002 Parameter DATA_NUM, default 4, is the number of elements per vector.
REQ-003 Parameter PIPE_LAT, default 4, is the number of datapath register stages per pass.
REQ-004 Ports (name, direction, width, meaning) SHALL be:
- clk  in  1  single clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when high together with in_valid.
- in_mode  in  2  mode: 00 softmax, 01 gelu, 10 silu, 11 root.
- in_data  in  DATA_NUM*FIX_POINT_WIDTH  input vector.
- dp_mode  out  2  datapath mode.
- dp_in  out  DATA_NUM*FIX_POINT_WIDTH  datapath input vector.
- dp_valid  out  1  datapath feedback enable.
- dp_s_in  out  3  datapath selector control.
- dp_s_mux  out  1  datapath selector control.
- dp_s_mult  out  3  datapath selector control.
- dp_s_add  out  1  datapath selector control.
- dp_en_add  out  1  datapath enable.
- dp_en_mult  out  1  datapath enable.
- dp_out  in  DATA_NUM*FIX_POINT_WIDTH  datapath result.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed.
- out_data  out  DATA_NUM*FIX_POINT_WIDTH  held result.

Function
REQ-005 FSM states SHALL be IDLE, P1, P2, CAPT, OUT; in_ready=1 only in IDLE.
REQ-006 IDLE with in_valid=1: next edge latches in_mode and in_data into internal registers, clears the pass counter, and enters P1.
REQ-007 dp_mode and dp_in SHALL always equal the latched registers, stable from acceptance until the next acceptance.
REQ-008 P1 and P2 SHALL each last exactly PIPE_LAT cycles, with counter 0..PIPE_LAT-1 cleared on entry.
REQ-009 Exit at count PIPE_LAT-1: P1 goes to P2 for modes 00 and 11, otherwise to CAPT; P2 goes to CAPT.
REQ-010 The control word is 10 bits: {s_in[9:7], s_mux[6], s_mult[5:3], s_add[2], en_add[1], en_mult[0]}, driven on the dp_s*/dp_en* ports.
REQ-011 Control words per mode:
- P1: softmax 0x005, gelu 0x112, silu 0x19A, root 0x263.
- P2: softmax 0x0CA, root 0x2EA.
- IDLE, CAPT and OUT: 0x000.
REQ-012 dp_valid=1 only in P2.
REQ-013 CAPT lasts one cycle; its closing edge loads dp_out into out_data, then enters OUT.
REQ-014 OUT: out_valid=1 and out_data held until out_valid&&out_ready; that edge returns to IDLE.
REQ-015 Latency: out_valid rises PIPE_LAT+2 cycles after the accept edge for one-pass modes and 2*PIPE_LAT+2 for two-pass modes (6 and 10 at default).
REQ-016 in_valid SHALL be ignored outside IDLE; in_mode/in_data changes after acceptance SHALL NOT affect the operation.
REQ-017 out_ready outside OUT SHALL be ignored; out_ready=1 on the first OUT cycle gives a one-cycle out_valid pulse.
REQ-018 Back-to-back requests: the earliest next accept is the cycle after OUT exits, so there is no overlap.

Reset
REQ-019 rst=1 at any edge, including mid-pass, SHALL force IDLE with all of the following zero: counter, latched mode/data, out_data, control word, dp_valid, out_valid.
REQ-020 in_ready SHALL be 1 on the first cycle after rst deasserts.

Structure
REQ-021 A shared package nolinear_pkg SHALL hold: mode encodings, state enumeration, control-word field positions, the six control-word constants, and PIPE_LAT default.
REQ-022 One sub-module, nolinear_ctrl_rom, SHALL be combinational and map (mode, pass) to the control word.

Verification
REQ-023 Gelu, in_data=0x0004_0003_0002_0001: control 0x112 for 4 cycles, dp_valid never 1, out_valid at cycle 6, out_data=dp_out sampled in CAPT.
REQ-024 Softmax: 0x005 for 4 cycles, then 0x0CA for 4 cycles with dp_valid=1, out_valid at cycle 10.
REQ-025 Root with out_ready held 0 for 5 cycles: out_valid and out_data stable; in_ready=0 throughout; IDLE the cycle after out_ready=1.
REQ-026 in_valid=1 with in_mode=11 during a silu P1: ignored, silu result unaffected, dp_mode stays 10.
REQ-027 rst=1 at P2 count 2: next cycle IDLE, all outputs zero, in_ready=1.
REQ-028 Two back-to-back silu requests with out_ready=1: second accept exactly one cycle after first OUT exit, no control overlap.

Source files
------------

// File: rtl/nolinear_pkg.sv
// Shared types and constants for the nonlinear-function datapath controller.
// Modes, FSM states and control-word layout/constants.
package nolinear_pkg;

  localparam int PIPE_LAT_DEF = 4;

  typedef enum logic [1:0] {
    MODE_SOFTMAX = 2'b00,
    MODE_GELU    = 2'b01,
    MODE_SILU    = 2'b10,
    MODE_ROOT    = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_P1,
    ST_P2,
    ST_CAPT,
    ST_OUT
  } state_e;

  localparam int CW_W        = 10;
  localparam int S_IN_MSB    = 9;
  localparam int S_IN_LSB    = 7;
  localparam int S_MUX_BIT   = 6;
  localparam int S_MULT_MSB  = 5;
  localparam int S_MULT_LSB  = 3;
  localparam int S_ADD_BIT   = 2;
  localparam int EN_ADD_BIT  = 1;
  localparam int EN_MULT_BIT = 0;

  typedef logic [CW_W-1:0] ctrl_word_t;

  localparam ctrl_word_t CW_NONE       = 10'h000;
  localparam ctrl_word_t CW_P1_SOFTMAX = 10'h005;
  localparam ctrl_word_t CW_P1_GELU    = 10'h112;
  localparam ctrl_word_t CW_P1_SILU    = 10'h19A;
  localparam ctrl_word_t CW_P1_ROOT    = 10'h263;
  localparam ctrl_word_t CW_P2_SOFTMAX = 10'h0CA;
  localparam ctrl_word_t CW_P2_ROOT    = 10'h2EA;

  function automatic logic two_pass(input mode_e m);
    return (m == MODE_SOFTMAX) || (m == MODE_ROOT);
  endfunction

endpackage

// File: rtl/nolinear_ctrl_rom.sv
// Combinational control-word lookup.
// Maps (mode, pass state) to the datapath selector/enable word.
module nolinear_ctrl_rom
  import nolinear_pkg::*;
(
  input  mode_e      mode_i,
  input  state_e     state_i,
  output ctrl_word_t ctrl_o
);

  always_comb begin
    ctrl_o = CW_NONE;
    unique case (1'b1)
      (state_i == ST_P1): begin
        unique case (mode_i)
          MODE_SOFTMAX: ctrl_o = CW_P1_SOFTMAX;
          MODE_GELU:    ctrl_o = CW_P1_GELU;
          MODE_SILU:    ctrl_o = CW_P1_SILU;
          MODE_ROOT:    ctrl_o = CW_P1_ROOT;
        endcase
      end
      (state_i == ST_P2): begin
        if (mode_i == MODE_SOFTMAX)
          ctrl_o = CW_P2_SOFTMAX;
        else if (mode_i == MODE_ROOT)
          ctrl_o = CW_P2_ROOT;
      end
      default: ctrl_o = CW_NONE;
    endcase
  end

endmodule

// File: rtl/nolinear_ctrl.sv
// Sequencer for the shared nonlinear datapath: accepts a vector,
// runs one or two fixed-latency passes, captures and holds the result.
module nolinear_ctrl
  import nolinear_pkg::*;
#(
  parameter int FIX_POINT_WIDTH = 16,
  parameter int DATA_NUM        = 4,
  parameter int PIPE_LAT        = PIPE_LAT_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [1:0]                          in_mode,
  input  logic [DATA_NUM*FIX_POINT_WIDTH-1:0] in_data,
  output logic [1:0]                          dp_mode,
  output logic [DATA_NUM*FIX_POINT_WIDTH-1:0] dp_in,
  output logic                                dp_valid,
  output logic [2:0]                          dp_s_in,
  output logic                                dp_s_mux,
  output logic [2:0]                          dp_s_mult,
  output logic                                dp_s_add,
  output logic                                dp_en_add,
  output logic                                dp_en_mult,
  input  logic [DATA_NUM*FIX_POINT_WIDTH-1:0] dp_out,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_NUM*FIX_POINT_WIDTH-1:0] out_data
);

  localparam int DW    = DATA_NUM * FIX_POINT_WIDTH;
  localparam int CNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIPE_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mode_e            mode_q, mode_d;
  logic [DW-1:0]    data_q, data_d;
  logic [DW-1:0]    res_q, res_d;
  ctrl_word_t       ctrl_q, ctrl_d;
  logic             dp_valid_q;
  logic             out_valid_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    data_d  = data_q;
    res_d   = res_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_P1;
          cnt_d   = '0;
          mode_d  = mode_e'(in_mode);
          data_d  = in_data;
        end
      end
      ST_P1: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = two_pass(mode_q) ? ST_P2 : ST_CAPT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_P2: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_CAPT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CAPT: begin
        res_d   = dp_out;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are looked up from the next state so they register in step with it.
  nolinear_ctrl_rom u_rom (
    .mode_i  (mode_d),
    .state_i (state_d),
    .ctrl_o  (ctrl_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mode_q      <= MODE_SOFTMAX;
      data_q      <= '0;
      res_q       <= '0;
      ctrl_q      <= CW_NONE;
      dp_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      data_q      <= data_d;
      res_q       <= res_d;
      ctrl_q      <= ctrl_d;
      dp_valid_q  <= (state_d == ST_P2);
      out_valid_q <= (state_d == ST_OUT);
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign dp_mode    = mode_q;
  assign dp_in      = data_q;
  assign dp_valid   = dp_valid_q;
  assign dp_s_in    = ctrl_q[S_IN_MSB:S_IN_LSB];
  assign dp_s_mux   = ctrl_q[S_MUX_BIT];
  assign dp_s_mult  = ctrl_q[S_MULT_MSB:S_MULT_LSB];
  assign dp_s_add   = ctrl_q[S_ADD_BIT];
  assign dp_en_add  = ctrl_q[EN_ADD_BIT];
  assign dp_en_mult = ctrl_q[EN_MULT_BIT];
  assign out_valid  = out_valid_q;
  assign out_data   = res_q;

endmodule

// File: tb/tb_nolinear_ctrl.sv
// Scoreboard bench for nolinear_ctrl with a cycle-stamped datapath stub.
// Directed requests cover each mode, stalls, ignored requests and reset.
module tb_nolinear_ctrl;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int P  = 4;
  localparam int DW = W * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_mode;
  logic [DW-1:0] in_data;
  logic [1:0]    dp_mode;
  logic [DW-1:0] dp_in;
  logic          dp_valid;
  logic [2:0]    dp_s_in;
  logic          dp_s_mux;
  logic [2:0]    dp_s_mult;
  logic          dp_s_add;
  logic          dp_en_add;
  logic          dp_en_mult;
  logic [DW-1:0] dp_out;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  nolinear_ctrl #(
    .FIX_POINT_WIDTH (W),
    .DATA_NUM        (N),
    .PIPE_LAT        (P)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mode    (in_mode),
    .in_data    (in_data),
    .dp_mode    (dp_mode),
    .dp_in      (dp_in),
    .dp_valid   (dp_valid),
    .dp_s_in    (dp_s_in),
    .dp_s_mux   (dp_s_mux),
    .dp_s_mult  (dp_s_mult),
    .dp_s_add   (dp_s_add),
    .dp_en_add  (dp_en_add),
    .dp_en_mult (dp_en_mult),
    .dp_out     (dp_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  always #5 clk = ~clk;

  // Datapath stub: output changes every cycle so the capture cycle is visible.
  logic [15:0] cyc = 16'd0;
  always @(posedge clk) cyc <= cyc + 16'd1;
  assign dp_out = dp_in ^ {4{cyc}};

  logic [9:0] cw;
  assign cw = {dp_s_in, dp_s_mux, dp_s_mult, dp_s_add, dp_en_add, dp_en_mult};

  int n_chk  = 0;
  int n_fail = 0;
  int last_a = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [9:0] p1w(input logic [1:0] m);
    case (m)
      2'b00:   return 10'h005;
      2'b01:   return 10'h112;
      2'b10:   return 10'h19A;
      default: return 10'h263;
    endcase
  endfunction

  function automatic logic [9:0] p2w(input logic [1:0] m);
    if (m == 2'b00) return 10'h0CA;
    if (m == 2'b11) return 10'h2EA;
    return 10'h000;
  endfunction

  always @(negedge clk) begin
    #1;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out: got %h expected none", out_data);
      end else begin
        chk("scoreboard_out_data", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic run_op(input logic [1:0] m, input logic [DW-1:0] d,
                        input int stall, input bit inject,
                        input int rst_at, input bit b2b);
    int a, lat, t;
    bit two;
    logic [9:0] ew;
    logic [DW-1:0] e;
    two = (m == 2'b00) || (m == 2'b11);
    lat = two ? 2 * P + 2 : P + 2;
    t = 0;
    while (!in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_before_accept", in_ready, 1);
    a = int'(cyc);
    if (b2b) chk("b2b_accept_gap", 64'(a - last_a), 64'(lat + 1));
    last_a = a;
    e = d ^ {4{16'(a + lat - 1)}};
    exp_q.push_back(e);
    in_valid  = 1'b1;
    in_mode   = m;
    in_data   = d;
    out_ready = (stall == 0);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) begin
        in_valid = inject;
        in_mode  = inject ? 2'b11 : ~m;
        in_data  = ~d;
      end
      if (k == 2) in_valid = 1'b0;
      if (rst_at == k) begin
        rst = 1'b1;
        void'(exp_q.pop_back());
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_ctrl", cw, 0);
        chk("rst_dp_valid", dp_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_dp_mode", dp_mode, 0);
        chk("rst_dp_in", dp_in, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1);
        return;
      end
      ew = (k <= P) ? p1w(m) : (two && k <= 2 * P) ? p2w(m) : 10'h000;
      chk("ctrl_word", cw, ew);
      chk("dp_valid", dp_valid, two && k > P && k <= 2 * P);
      chk("out_valid_timing", out_valid, k == lat);
      chk("in_ready_busy", in_ready, 0);
      chk("dp_mode_held", dp_mode, m);
      chk("dp_in_held", dp_in, d);
    end
    chk("out_data_at_valid", out_data, e);
    for (int s = 1; s <= stall; s++) begin
      @(negedge clk);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_data", out_data, e);
      chk("stall_in_ready", in_ready, 0);
      if (s == stall) out_ready = 1'b1;
    end
    @(negedge clk);
    chk("idle_after_out", in_ready, 1);
    chk("out_valid_drop", out_valid, 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 2'b00;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_ctrl", cw, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_dp_valid", dp_valid, 0);
    chk("reset_out_data", out_data, 0);
    run_op(2'b01, 64'h0004_0003_0002_0001, 0, 1'b0, 0, 1'b0);
    run_op(2'b00, 64'h1111_2222_3333_4444, 0, 1'b0, 0, 1'b0);
    run_op(2'b11, 64'hDEAD_BEEF_0123_4567, 5, 1'b0, 0, 1'b0);
    run_op(2'b10, 64'h0F0F_00FF_5555_AAAA, 0, 1'b1, 0, 1'b0);
    run_op(2'b00, 64'h7777_8888_9999_AAAA, 0, 1'b0, P + 3, 1'b0);
    run_op(2'b10, 64'h0102_0304_0506_0708, 0, 1'b0, 0, 1'b0);
    run_op(2'b10, 64'hCAFE_F00D_1234_8765, 0, 1'b0, 0, 1'b1);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
